// File: rtl/irq_pending_collector.sv
// Pending-request collector in front of an external 8-to-3 priority encoder; offers the returned id over valid/ready.
// Optional build macro IRQ_EDGE_DETECT_EN: rising-edge request capture with sticky overrun detection.
module irq_pending_collector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       clr_all,
    output logic [7:0] pend_out,
    output logic       pend_en,
    input  logic [2:0] code_in,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    input  logic       irq_ready,
    output logic [3:0] pend_cnt,
    output logic       overrun
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       irq_valid_q, irq_valid_d;
    logic [2:0] irq_id_q, irq_id_d;
    logic       overrun_q, overrun_d;
    logic [7:0] set_s;
    logic [7:0] acc_clr_s;
    logic [7:0] pend_masked_s;
    logic       accept_s;

`ifdef IRQ_EDGE_DETECT_EN
    logic [7:0] req_q, req_d;

    // Edge history: previous-cycle request lines.
    always_comb begin
        req_d = req_in;
    end

    // Edge history register; cleared by reset so a line already high counts as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= 8'h00;
        end else begin
            req_q <= req_d;
        end
    end

    assign set_s = req_in & ~req_q;
`else
    assign set_s = req_in;
`endif

    assign pend_masked_s = pend_q & mask;
    assign pend_out      = pend_masked_s;
    assign pend_en       = |pend_masked_s;
    assign pend_cnt      = popcount8(pend_masked_s);
    assign irq_valid     = irq_valid_q;
    assign irq_id        = irq_id_q;
    assign overrun       = overrun_q;

    // Pending next-state: flush beats new sets, and a new set beats the accept-clear.
    always_comb begin
        accept_s  = (state_q == ST_OFFER) && irq_ready;
        acc_clr_s = accept_s ? (8'h01 << irq_id_q) : 8'h00;
        if (clr_all) begin
            pend_d    = 8'h00;
            overrun_d = 1'b0;
        end else begin
            pend_d    = (pend_q & ~acc_clr_s) | set_s;
`ifdef IRQ_EDGE_DETECT_EN
            overrun_d = overrun_q | (|(set_s & pend_q & ~acc_clr_s));
`else
            overrun_d = 1'b0;
`endif
        end
    end

    // Offer FSM: capture the encoder code when anything visible is pending, hold until accepted.
    always_comb begin
        state_d     = state_q;
        irq_valid_d = irq_valid_q;
        irq_id_d    = irq_id_q;
        if (clr_all) begin
            state_d     = ST_IDLE;
            irq_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_en) begin
                        state_d     = ST_OFFER;
                        irq_valid_d = 1'b1;
                        irq_id_d    = code_in;
                    end else begin
                        state_d     = ST_IDLE;
                        irq_valid_d = 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (irq_ready) begin
                        state_d     = ST_IDLE;
                        irq_valid_d = 1'b0;
                    end else begin
                        state_d     = ST_OFFER;
                        irq_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, pending and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= 8'h00;
            irq_valid_q <= 1'b0;
            irq_id_q    <= 3'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            overrun_q   <= overrun_d;
        end
    end

    irq_pending_collector_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_all   (clr_all),
        .irq_valid (irq_valid_q),
        .irq_ready (irq_ready),
        .irq_id    (irq_id_q),
        .pend_out  (pend_masked_s),
        .pend_en   (pend_en),
        .pend_cnt  (pend_cnt)
    );

endmodule

// Protocol checker: offers are stable until accepted, and the encoder-side outputs stay consistent.
module irq_pending_collector_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       clr_all,
    input logic       irq_valid,
    input logic       irq_ready,
    input logic [2:0] irq_id,
    input logic [7:0] pend_out,
    input logic       pend_en,
    input logic [3:0] pend_cnt
);

    a_offer_held: assert property (@(posedge clk) disable iff (!rst_n)
        (irq_valid && !irq_ready && !clr_all) |=> (irq_valid && (irq_id == $past(irq_id))));

    a_accept_drops: assert property (@(posedge clk) disable iff (!rst_n)
        (irq_valid && irq_ready) |=> !irq_valid);

    a_enc_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (pend_en == (|pend_out)) && (pend_cnt <= 4'd8));

endmodule

// File: tb/tb_irq_pending_collector.sv
// Self-checking bench for irq_pending_collector: table vectors, directed corner sequences, random run vs. reference model.
module tb_irq_pending_collector;

`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, clr_all, irq_ready;
    logic [7:0] req_in, mask;
    logic [7:0] pend_out;
    logic       pend_en, irq_valid, overrun;
    logic [2:0] code_in, irq_id;
    logic [3:0] pend_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_pending_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .clr_all   (clr_all),
        .pend_out  (pend_out),
        .pend_en   (pend_en),
        .code_in   (code_in),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ready (irq_ready),
        .pend_cnt  (pend_cnt),
        .overrun   (overrun)
    );

    // Encoder stand-in: highest set input bit wins.
    always_comb begin
        code_in = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_out[i]) code_in = 3'(i);
        end
    end

    // Reference model state
    bit         m_pend [8];
    bit         m_offer;
    int         m_id;
    bit         m_ovr;
    bit [7:0]   m_prev_req;

    function automatic int top_pending(input bit [7:0] vis);
        for (int i = 7; i >= 0; i--) begin
            if (vis[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit [7:0] model_visible();
        bit [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i] & mask[i];
        return v;
    endfunction

    task automatic model_edge();
        bit [7:0] set_ev;
        bit [7:0] vis;
        bit       acc;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_offer    = 1'b0;
            m_id       = 0;
            m_ovr      = 1'b0;
            m_prev_req = 8'h00;
        end else begin
            set_ev = EDGE_MODE ? (req_in & ~m_prev_req) : req_in;
            vis    = model_visible();
            acc    = m_offer && irq_ready;
            if (clr_all) begin
                for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
                m_offer = 1'b0;
                m_ovr   = 1'b0;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (EDGE_MODE && set_ev[i] && m_pend[i] && !(acc && i == m_id)) m_ovr = 1'b1;
                end
                if (acc) m_pend[m_id] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (set_ev[i]) m_pend[i] = 1'b1;
                end
                if (m_offer) begin
                    if (irq_ready) m_offer = 1'b0;
                end else if (vis != 8'h00) begin
                    m_offer = 1'b1;
                    m_id    = top_pending(vis);
                end
            end
            m_prev_req = req_in;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        bit [7:0] v;
        @(posedge clk);
        #1;
        model_edge();
        v = model_visible();
        check("model", {14'd0, irq_valid, irq_id, pend_out, pend_en, pend_cnt, overrun},
              {14'd0, m_offer, 3'(m_id), v, (v != 8'h00), 4'($countones(v)), m_ovr});
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_in    = 8'h00;
        mask      = 8'hFF;
        clr_all   = 1'b0;
        irq_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] mask;
        logic       clr;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst_n     = 1'b0;
        req_in    = 8'h00;
        mask      = 8'hFF;
        clr_all   = 1'b0;
        irq_ready = 1'b0;

        // Priority drain of 1010_0100: ids 7, 5, 2 two cycles apart.
        tbl[0] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0};
        tbl[1] = '{1'b1, 8'hA4, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'hA4, 4'd3};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd7, 8'hA4, 4'd3};
        tbl[3] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd7, 8'h24, 4'd2};
        tbl[4] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd5, 8'h24, 4'd2};
        tbl[5] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd5, 8'h04, 4'd1};
        tbl[6] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 4'd1};
        tbl[7] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 4'd0};
        tbl[8] = '{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 4'd0};

        for (int r = 0; r < 9; r++) begin
            rst_n     = tbl[r].rst_n;
            req_in    = tbl[r].req;
            mask      = tbl[r].mask;
            clr_all   = tbl[r].clr;
            irq_ready = tbl[r].ready;
            step();
            check("tbl_valid", {31'd0, irq_valid}, {31'd0, tbl[r].exp_valid});
            check("tbl_id", {29'd0, irq_id}, {29'd0, tbl[r].exp_id});
            check("tbl_pend", {24'd0, pend_out}, {24'd0, tbl[r].exp_pend});
            check("tbl_cnt", {28'd0, pend_cnt}, {28'd0, tbl[r].exp_cnt});
        end

        // Stalled offer of id 6 stays put while id 7 arrives.
        do_reset();
        req_in = 8'h40; step();
        req_in = 8'h00; step();
        check("s2_first_id", {29'd0, irq_id}, 32'd6);
        for (int k = 0; k < 10; k++) begin
            req_in = (k == 3) ? 8'h80 : 8'h00;
            step();
            check("s2_hold_valid", {31'd0, irq_valid}, 32'd1);
            check("s2_hold_id", {29'd0, irq_id}, 32'd6);
        end
        req_in = 8'h00; irq_ready = 1'b1; step();
        check("s2_accept_valid", {31'd0, irq_valid}, 32'd0);
        step();
        check("s2_next_valid", {31'd0, irq_valid}, 32'd1);
        check("s2_next_id", {29'd0, irq_id}, 32'd7);
        step();
        irq_ready = 1'b0;

        // Masked line held pending but hidden until unmasked.
        do_reset();
        mask = 8'h0F; req_in = 8'h42; step();
        req_in = 8'h00;
        check("s3_pend_out", {24'd0, pend_out}, 32'h02);
        check("s3_cnt", {28'd0, pend_cnt}, 32'd1);
        step();
        check("s3_id1", {28'd0, irq_valid, irq_id}, 32'h9);
        irq_ready = 1'b1; step();
        check("s3_cnt_hidden", {28'd0, pend_cnt}, 32'd0);
        check("s3_no_offer", {31'd0, irq_valid}, 32'd0);
        irq_ready = 1'b0; mask = 8'hFF; step();
        check("s3_id6", {28'd0, irq_valid, irq_id}, 32'hE);
        irq_ready = 1'b1; step();
        irq_ready = 1'b0;

        // Double request on a pending line, then flush.
        do_reset();
        req_in = 8'h08; step();
        req_in = 8'h00; step();
        check("s4_id3", {28'd0, irq_valid, irq_id}, 32'hB);
        req_in = 8'h08; step();
        req_in = 8'h00; step();
        check("s4_overrun", {31'd0, overrun}, EDGE_MODE ? 32'd1 : 32'd0);
        irq_ready = 1'b1; step();
        check("s4_accept_valid", {31'd0, irq_valid}, 32'd0);
        step();
        check("s4_single_offer", {31'd0, irq_valid}, 32'd0);
        check("s4_pend_empty", {24'd0, pend_out}, 32'h00);
        irq_ready = 1'b0; req_in = 8'h08; step();
        req_in = 8'h00; clr_all = 1'b1; step();
        clr_all = 1'b0;
        check("s4_clr_overrun", {31'd0, overrun}, 32'd0);
        check("s4_clr_pend", {24'd0, pend_out}, 32'h00);
        check("s4_clr_valid", {31'd0, irq_valid}, 32'd0);

        // Flush during an offer that is being accepted.
        do_reset();
        req_in = 8'h11; step();
        req_in = 8'h00; step();
        check("s5_id4", {28'd0, irq_valid, irq_id}, 32'hC);
        clr_all = 1'b1; irq_ready = 1'b1; step();
        clr_all = 1'b0;
        check("s5_valid", {31'd0, irq_valid}, 32'd0);
        check("s5_pend", {24'd0, pend_out}, 32'h00);
        check("s5_cnt", {28'd0, pend_cnt}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("s5_quiet", {31'd0, irq_valid}, 32'd0);
        end
        irq_ready = 1'b0;

        // Line held high through reset is offered two cycles after release.
        rst_n = 1'b0; req_in = 8'h10; mask = 8'hFF;
        repeat (3) step();
        check("s6_reset_valid", {31'd0, irq_valid}, 32'd0);
        rst_n = 1'b1; step();
        check("s6_pend", {24'd0, pend_out}, 32'h10);
        check("s6_not_yet", {31'd0, irq_valid}, 32'd0);
        step();
        check("s6_offer", {28'd0, irq_valid, irq_id}, 32'hC);
        req_in = 8'h00; irq_ready = 1'b1; step();
        irq_ready = 1'b0; step();

        // Randomized run against the reference model.
        mask = 8'hFF;
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            clr_all   = ($urandom_range(0, 79) == 0);
            irq_ready = ($urandom_range(0, 2) != 0);
            req_in    = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            if ($urandom_range(0, 31) == 0) mask = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_pending_collector.md
# irq_pending_collector

Upstream stage of the 8-to-3 priority encoder.
- Latches eight interrupt request lines into a pending register and applies a per-line mask.
- Drives the encoder's 8-bit input and enable, then takes back its 3-bit code.
- Offers that code to a consumer over a valid/ready handshake.
- Clears the served pending bit on acceptance, so lower-priority requests are served in turn.

## Interface
Parameters:
- none; width fixed at 8 requests / 3-bit id to match the encoder.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_in  in  8  raw request lines, synchronous to clk
- mask  in  8  1 = line enabled; 0 = line held pending but hidden
- clr_all  in  1  flush all pending bits and the sticky overrun flag
- pend_out  out  8  pend & mask; connects to encoder in
- pend_en  out  1  |(pend & mask); connects to encoder en
- code_in  in  3  encoder out; ignored when pend_en = 0 (encoder drives z)
- irq_valid  out  1  offer active
- irq_id  out  3  id of offered request, registered
- irq_ready  in  1  consumer accepts offer
- pend_cnt  out  4  popcount(pend & mask), 0..8
- overrun  out  1  sticky; a request arrived for an already-pending line

## Operation
- Pending register `pend[7:0]`:
  - set from the request source (see Configuration);
  - bit irq_id cleared on accept (irq_valid & irq_ready).
- Priority within a cycle: clr_all > set > accept-clear.
  - A new set on the bit being accepted leaves it pending.
  - That case does not flag overrun.
- pend_out, pend_en and pend_cnt are combinational from `pend` and `mask`. No other logic sits in that path.
- FSM, two states:
  - IDLE: irq_valid = 0. If pend_en = 1, capture code_in into irq_id and go to OFFER.
  - OFFER: irq_valid = 1 and irq_id held stable. On irq_ready, clear pend[irq_id] and go to IDLE.
- Offer is never retracted except by clr_all or reset.
  - Clearing mask[irq_id] during OFFER does not drop the offer.
- clr_all in any state:
  - next cycle pend = 0, overrun = 0, state IDLE, irq_valid = 0;
  - an accept in the same cycle is absorbed.
- Overrun is set when a set event targets a bit already 1 that is not being accepted that cycle. It is held until clr_all or reset.
- Reset values:
  - pend = 0, irq_valid = 0, irq_id = 0, overrun = 0, state IDLE;
  - therefore pend_out = 0, pend_en = 0, pend_cnt = 0;
  - edge-history register = 0.

## Timing
- Request sampled at edge N sets pend at N. pend_out and pend_en are valid after N.
- Code is captured at N+1, and irq_valid is high after N+1 (2-cycle request-to-offer latency).
- Accept at edge M: pend bit clears at M and state returns to IDLE.
  - The next offer is captured at M+1.
  - Sustained throughput is one grant per 2 cycles.
- code_in must settle within the same cycle as pend_out (encoder is combinational). No registered path is allowed between them.
- Reset asserted mid-OFFER: irq_valid low after the reset edge, and the pending request is lost.

## Configuration
- IRQ_EDGE_DETECT_EN defined:
  - set event = req_in & ~req_q, where req_q is req_in registered;
  - overrun is active;
  - a line already high at reset release produces an edge in the first cycle after reset.
- Not defined:
  - level-sensitive, set event = req_in every cycle;
  - overrun tied to 0;
  - a line held high re-pends immediately after being served.

## Test plan
- Reset then req_in = 8'b1010_0100 pulse, mask = 8'hFF, irq_ready = 1 → irq_valid with irq_id = 7, then 5, then 2, each offer 2 cycles apart; pend_cnt 3→2→1→0.
- Offer of id 6 with irq_ready low for 10 cycles while req_in[7] rises → irq_id stays 6 and irq_valid stays high; after accept, next offer is id 7.
- mask = 8'h0F, req_in[6] and req_in[1] pulse → only id 1 offered, pend_cnt = 1; set mask = 8'hFF → id 6 offered next.
- Edge mode: pulse req_in[3] twice before accept → overrun = 1, single offer of id 3; clr_all → overrun = 0, pend_out = 0.
- clr_all asserted during OFFER together with irq_ready → irq_valid = 0 and pend = 0 next cycle, no further offers.
- Edge mode: rst_n low for 3 cycles while req_in[4] is high → after release, id 4 is offered at the 2-cycle latency.
